// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read ports, one
// byte-enabled write port (active-low enable), optional hardwired zero register,
// optional write-to-read bypass and a sequential clear engine (one entry per cycle).

module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_W-1:0]     R_Addr_A,
  input  logic [ADDR_W-1:0]     R_Addr_B,
  input  logic [ADDR_W-1:0]     W_Addr,
  input  logic [DATA_W-1:0]     W_Data,
  input  logic                  We,
  input  logic [DATA_W/8-1:0]   W_Be,
  input  logic                  Clr,
  output logic [DATA_W-1:0]     R_Data_A,
  output logic [DATA_W-1:0]     R_Data_B,
  output logic                  Busy,
  output logic                  Wr_Err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic                r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_wr_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_go;
  logic                w_wr_zero;
  logic                w_drop;
  logic                w_last;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;

  // Byte-wise merge of new write data over a stored word.
  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] new_word,
                                                input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Write qualification: a write only lands in IDLE without a competing clear request.
  always_comb begin
    w_wr_go   = (r_state == ST_IDLE) && !Clr && !We;
    w_wr_zero = ZERO_REG && (W_Addr == '0);
    // A write is dropped when it collides with a clear request or a running clear.
    w_drop    = !We && ((r_state == ST_CLEAR) || Clr);
    w_last    = (r_ptr == {ADDR_W{1'b1}});
  end

  // Clear FSM and its pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Clr) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Dropped-write flag, one cycle after the offending write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_drop;
    end
  end

  // Storage array: clear engine has priority over the write port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_go && !w_wr_zero) begin
      for (int k = 0; k < NB; k++) begin
        if (W_Be[k]) begin
          r_mem[W_Addr][8*k +: 8] <= W_Data[8*k +: 8];
        end
      end
    end
  end

  // Read port A: array, optional bypass of the in-flight write, zero register last.
  always_comb begin
    w_rd_a = r_mem[R_Addr_A];
    if (BYPASS && w_wr_go && (R_Addr_A == W_Addr)) begin
      w_rd_a = f_merge(r_mem[R_Addr_A], W_Data, W_Be);
    end
    if (ZERO_REG && (R_Addr_A == '0)) begin
      w_rd_a = '0;
    end
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    w_rd_b = r_mem[R_Addr_B];
    if (BYPASS && w_wr_go && (R_Addr_B == W_Addr)) begin
      w_rd_b = f_merge(r_mem[R_Addr_B], W_Data, W_Be);
    end
    if (ZERO_REG && (R_Addr_B == '0)) begin
      w_rd_b = '0;
    end
  end

  assign R_Data_A = w_rd_a;
  assign R_Data_B = w_rd_b;
  assign Busy     = (r_state == ST_CLEAR);
  assign Wr_Err   = r_wr_err;

endmodule
